// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and a saturating count of inserted bubbles.
module id_ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_pc,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    input  logic [AW-1:0]   id_rs_addr,
    input  logic [AW-1:0]   id_rt_addr,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_uses_rt,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_alu_src,
    input  logic            id_reg_dst,
    input  logic [3:0]      id_alu_op,
    input  logic            flush,
    input  logic            mem_stall,
    output logic            ie_valid,
    output logic [DW-1:0]   ie_pc,
    output logic [DW-1:0]   ie_rs_data,
    output logic [DW-1:0]   ie_rt_data,
    output logic [DW-1:0]   ie_imm,
    output logic [AW-1:0]   ie_rs_addr,
    output logic [AW-1:0]   ie_rt_addr,
    output logic [AW-1:0]   ie_wr_addr,
    output logic            ie_reg_write,
    output logic            ie_mem_read,
    output logic            ie_mem_write,
    output logic            ie_mem_to_reg,
    output logic            ie_alu_src,
    output logic [3:0]      ie_alu_op,
    output logic            hold_if_id,
    output logic [CNTW-1:0] bubble_cnt
);

    logic            lu;
    logic            bubble;
    logic            valid_d, reg_write_d, mem_read_d, mem_write_d, mem_to_reg_d, alu_src_d;
    logic [DW-1:0]   pc_d, rs_data_d, rt_data_d, imm_d;
    logic [AW-1:0]   rs_addr_d, rt_addr_d, wr_addr_d;
    logic [3:0]      alu_op_d;
    logic [CNTW-1:0] cnt_d;

    // A load into $0 never stalls: the write is discarded anyway.
    assign lu = ie_valid & ie_mem_read & (ie_wr_addr != '0) & id_valid &
                ((ie_wr_addr == id_rs_addr) | (id_uses_rt & (ie_wr_addr == id_rt_addr)));

    assign bubble     = flush | lu;
    assign hold_if_id = rst_n & (mem_stall | (~flush & lu));

    always_comb begin
        valid_d      = ie_valid;
        pc_d         = ie_pc;
        rs_data_d    = ie_rs_data;
        rt_data_d    = ie_rt_data;
        imm_d        = ie_imm;
        rs_addr_d    = ie_rs_addr;
        rt_addr_d    = ie_rt_addr;
        wr_addr_d    = ie_wr_addr;
        reg_write_d  = ie_reg_write;
        mem_read_d   = ie_mem_read;
        mem_write_d  = ie_mem_write;
        mem_to_reg_d = ie_mem_to_reg;
        alu_src_d    = ie_alu_src;
        alu_op_d     = ie_alu_op;
        cnt_d        = bubble_cnt;
        if (!mem_stall) begin
            if (bubble) begin
                valid_d      = 1'b0;
                pc_d         = '0;
                rs_data_d    = '0;
                rt_data_d    = '0;
                imm_d        = '0;
                rs_addr_d    = '0;
                rt_addr_d    = '0;
                wr_addr_d    = '0;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                alu_src_d    = 1'b0;
                alu_op_d     = '0;
                if (bubble_cnt != '1) cnt_d = bubble_cnt + 1'b1;
            end else begin
                valid_d      = id_valid;
                pc_d         = id_pc;
                rs_data_d    = id_rs_data;
                rt_data_d    = id_rt_data;
                imm_d        = id_imm;
                rs_addr_d    = id_rs_addr;
                rt_addr_d    = id_rt_addr;
                wr_addr_d    = id_reg_dst ? id_rd_addr : id_rt_addr;
                reg_write_d  = id_valid & id_reg_write;
                mem_read_d   = id_valid & id_mem_read;
                mem_write_d  = id_valid & id_mem_write;
                mem_to_reg_d = id_valid & id_mem_to_reg;
                alu_src_d    = id_valid & id_alu_src;
                alu_op_d     = id_valid ? id_alu_op : 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_valid      <= 1'b0;
            ie_pc         <= '0;
            ie_rs_data    <= '0;
            ie_rt_data    <= '0;
            ie_imm        <= '0;
            ie_rs_addr    <= '0;
            ie_rt_addr    <= '0;
            ie_wr_addr    <= '0;
            ie_reg_write  <= 1'b0;
            ie_mem_read   <= 1'b0;
            ie_mem_write  <= 1'b0;
            ie_mem_to_reg <= 1'b0;
            ie_alu_src    <= 1'b0;
            ie_alu_op     <= '0;
            bubble_cnt    <= '0;
        end else begin
            ie_valid      <= valid_d;
            ie_pc         <= pc_d;
            ie_rs_data    <= rs_data_d;
            ie_rt_data    <= rt_data_d;
            ie_imm        <= imm_d;
            ie_rs_addr    <= rs_addr_d;
            ie_rt_addr    <= rt_addr_d;
            ie_wr_addr    <= wr_addr_d;
            ie_reg_write  <= reg_write_d;
            ie_mem_read   <= mem_read_d;
            ie_mem_write  <= mem_write_d;
            ie_mem_to_reg <= mem_to_reg_d;
            ie_alu_src    <= alu_src_d;
            ie_alu_op     <= alu_op_d;
            bubble_cnt    <= cnt_d;
        end
    end

endmodule
